reg_file_bist: RTL and testbench



---
 rtl/reg_file_bist.sv | 158 +++++++++++++++
 tb/tb_reg_file_bist.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_file_bist.sv
// reg_file_bist: write-then-read-back self test of a two-read-port register file.
// Define BIST_STOP_ON_FAIL_EN to end a run at the first mismatching address.
module reg_file_bist #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 5,
   parameter int FIRST_ADDR = 1,
   parameter int LAST_ADDR  = 31,
   parameter int READ_LAT   = 1
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  START,
   input  logic [DATA_WIDTH-1:0] SEED,
   output logic [ADDR_WIDTH-1:0] ADDR_W,
   output logic [ADDR_WIDTH-1:0] ADDR_R1,
   output logic [ADDR_WIDTH-1:0] ADDR_R2,
   output logic [DATA_WIDTH-1:0] DATA_W,
   output logic                  READ,
   output logic                  WRITE,
   input  logic [DATA_WIDTH-1:0] DATA_R1,
   input  logic [DATA_WIDTH-1:0] DATA_R2,
   output logic                  BUSY,
   output logic                  DONE,
   output logic                  ERROR,
   output logic [ADDR_WIDTH-1:0] FAIL_ADDR,
   output logic [ADDR_WIDTH:0]   TEST_COUNT,
   output logic [ADDR_WIDTH:0]   PASS_COUNT
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_WR   = 2'd1;
   localparam logic [1:0] ST_RD   = 2'd2;
   localparam logic [1:0] ST_DONE = 2'd3;

   localparam int CW = ADDR_WIDTH + 1;
   localparam logic [ADDR_WIDTH-1:0] A_FIRST = ADDR_WIDTH'(FIRST_ADDR);
   localparam logic [ADDR_WIDTH-1:0] A_LAST  = ADDR_WIDTH'(LAST_ADDR);
   localparam logic [CW-1:0] N_ADDR = CW'(LAST_ADDR - FIRST_ADDR + 1);
   localparam logic [1:0] LAT_MAX = 2'(READ_LAT);

   logic [1:0]            state;
   logic [ADDR_WIDTH-1:0] addr;
   logic [1:0]            lat_cnt;
   logic [DATA_WIDTH-1:0] seed_q;
   logic [DATA_WIDTH-1:0] pattern;
   logic [CW-1:0]         test_cnt;
   logic [CW-1:0]         pass_cnt;
   logic                  err_q;
   logic [ADDR_WIDTH-1:0] fail_q;

   logic in_wr;
   logic in_rd;
   logic at_last;
   logic win_end;
   logic match;
   logic start_ok;
   logic stop_run;

   always_comb begin
      pattern = '0;
      pattern[ADDR_WIDTH:0] = {addr, 1'b0};
      pattern = pattern ^ seed_q;
   end

   assign in_wr    = (state == ST_WR);
   assign in_rd    = (state == ST_RD);
   assign at_last  = (addr == A_LAST);
   assign win_end  = in_rd && (lat_cnt == LAT_MAX);
   assign match    = (DATA_R1 == pattern) && (DATA_R2 == pattern);
   assign start_ok = START && ((state == ST_IDLE) || (state == ST_DONE));

`ifdef BIST_STOP_ON_FAIL_EN
   assign stop_run = win_end && !match;
`else
   assign stop_run = 1'b0;
`endif

   // read data is sampled only on the last cycle of each address window
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state   <= ST_IDLE;
         addr    <= '0;
         lat_cnt <= '0;
         seed_q  <= '0;
      end else begin
         unique case (state)
            ST_IDLE, ST_DONE: begin
               if (START) begin
                  state   <= ST_WR;
                  addr    <= A_FIRST;
                  lat_cnt <= '0;
                  seed_q  <= SEED;
               end
            end
            ST_WR: begin
               if (at_last) begin
                  state <= ST_RD;
                  addr  <= A_FIRST;
               end else begin
                  addr <= addr + 1'b1;
               end
            end
            ST_RD: begin
               if (!win_end) begin
                  lat_cnt <= lat_cnt + 2'd1;
               end else begin
                  lat_cnt <= '0;
                  if (at_last || stop_run) begin
                     state <= ST_DONE;
                  end else begin
                     addr <= addr + 1'b1;
                  end
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         test_cnt <= '0;
         pass_cnt <= '0;
         err_q    <= 1'b0;
         fail_q   <= '0;
      end else if (start_ok) begin
         test_cnt <= '0;
         pass_cnt <= '0;
         err_q    <= 1'b0;
         fail_q   <= '0;
      end else if (win_end) begin
         if (test_cnt != N_ADDR) begin
            test_cnt <= test_cnt + 1'b1;
         end
         if (match && (pass_cnt != N_ADDR)) begin
            pass_cnt <= pass_cnt + 1'b1;
         end
         if (!match && !err_q) begin
            err_q  <= 1'b1;
            fail_q <= addr;
         end
      end
   end

   assign WRITE      = in_wr;
   assign READ       = in_rd;
   assign ADDR_W     = in_wr ? addr : '0;
   assign DATA_W     = in_wr ? pattern : '0;
   assign ADDR_R1    = in_rd ? addr : '0;
   assign ADDR_R2    = in_rd ? addr : '0;
   assign BUSY       = in_wr || in_rd;
   assign DONE       = (state == ST_DONE);
   assign ERROR      = err_q;
   assign FAIL_ADDR  = fail_q;
   assign TEST_COUNT = test_cnt;
   assign PASS_COUNT = pass_cnt;

endmodule

// File: tb/tb_reg_file_bist.sv
// tb_reg_file_bist: three BIST configurations against a behavioural two-port
// register file with injectable stuck-at and read-port faults.
module tb_reg_file_bist;

   localparam int NI = 3;

   int fa_p[NI] = '{1, 3, 2};
   int la_p[NI] = '{31, 3, 9};
   int rl_p[NI] = '{1, 0, 2};

   logic clk = 1'b0;
   logic rst = 1'b1;

   logic        start   [NI];
   logic [31:0] seed    [NI];
   logic [4:0]  addr_w  [NI];
   logic [4:0]  addr_r1 [NI];
   logic [4:0]  addr_r2 [NI];
   logic [31:0] data_w  [NI];
   logic [31:0] dr1     [NI];
   logic [31:0] dr2     [NI];
   logic        rd      [NI];
   logic        wr      [NI];
   logic        busy    [NI];
   logic        done    [NI];
   logic        err     [NI];
   logic [4:0]  fa      [NI];
   logic [5:0]  tc      [NI];
   logic [5:0]  pc      [NI];

   logic [31:0] or_mask [32];
   logic [31:0] x2_mask [32];
   logic [31:0] mem     [NI][32];
   logic [31:0] now1    [NI];
   logic [31:0] now2    [NI];
   logic [31:0] p1      [NI][2];
   logic [31:0] p2      [NI][2];

   int n_assert = 0;
   int n_fail   = 0;
   int excl_bad = 0;
   int cur      = 0;
   logic [36:0] wr_log[$];

   always #5 clk = ~clk;

   reg_file_bist u_dut0 (
      .CLK(clk), .RST(rst), .START(start[0]), .SEED(seed[0]),
      .ADDR_W(addr_w[0]), .ADDR_R1(addr_r1[0]), .ADDR_R2(addr_r2[0]),
      .DATA_W(data_w[0]), .READ(rd[0]), .WRITE(wr[0]),
      .DATA_R1(dr1[0]), .DATA_R2(dr2[0]), .BUSY(busy[0]), .DONE(done[0]),
      .ERROR(err[0]), .FAIL_ADDR(fa[0]), .TEST_COUNT(tc[0]), .PASS_COUNT(pc[0])
   );

   reg_file_bist #(.FIRST_ADDR(3), .LAST_ADDR(3), .READ_LAT(0)) u_dut1 (
      .CLK(clk), .RST(rst), .START(start[1]), .SEED(seed[1]),
      .ADDR_W(addr_w[1]), .ADDR_R1(addr_r1[1]), .ADDR_R2(addr_r2[1]),
      .DATA_W(data_w[1]), .READ(rd[1]), .WRITE(wr[1]),
      .DATA_R1(dr1[1]), .DATA_R2(dr2[1]), .BUSY(busy[1]), .DONE(done[1]),
      .ERROR(err[1]), .FAIL_ADDR(fa[1]), .TEST_COUNT(tc[1]), .PASS_COUNT(pc[1])
   );

   reg_file_bist #(.FIRST_ADDR(2), .LAST_ADDR(9), .READ_LAT(2)) u_dut2 (
      .CLK(clk), .RST(rst), .START(start[2]), .SEED(seed[2]),
      .ADDR_W(addr_w[2]), .ADDR_R1(addr_r1[2]), .ADDR_R2(addr_r2[2]),
      .DATA_W(data_w[2]), .READ(rd[2]), .WRITE(wr[2]),
      .DATA_R1(dr1[2]), .DATA_R2(dr2[2]), .BUSY(busy[2]), .DONE(done[2]),
      .ERROR(err[2]), .FAIL_ADDR(fa[2]), .TEST_COUNT(tc[2]), .PASS_COUNT(pc[2])
   );

   // register file model: faults on write (stuck bits) and on read port 2
   always_comb begin
      for (int k = 0; k < NI; k++) begin
         now1[k] = mem[k][addr_r1[k]];
         now2[k] = mem[k][addr_r2[k]] ^ x2_mask[addr_r2[k]];
      end
   end

   always @(posedge clk) begin
      for (int k = 0; k < NI; k++) begin
         if (wr[k]) mem[k][addr_w[k]] <= data_w[k] | or_mask[addr_w[k]];
         p1[k][0] <= now1[k];
         p1[k][1] <= p1[k][0];
         p2[k][0] <= now2[k];
         p2[k][1] <= p2[k][0];
      end
   end

   assign dr1[0] = p1[0][0];
   assign dr2[0] = p2[0][0];
   assign dr1[1] = now1[1];
   assign dr2[1] = now2[1];
   assign dr1[2] = p1[2][1];
   assign dr2[2] = p2[2][1];

   always @(negedge clk) begin
      for (int k = 0; k < NI; k++)
         if ((rd[k] && wr[k]) || (busy[k] && done[k])) excl_bad++;
      if (wr[cur]) wr_log.push_back({addr_w[cur], data_w[cur]});
   end

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      n_assert++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] pat(input int a, input logic [31:0] s);
      return (32'(a) * 32'd2) ^ s;
   endfunction

   function automatic bit addr_ok(input int a, input logic [31:0] s);
      logic [31:0] w;
      w = pat(a, s) | or_mask[a];
      return (w == pat(a, s)) && ((w ^ x2_mask[a]) == pat(a, s));
   endfunction

   task automatic model(input int k, input logic [31:0] s,
                        output int e_tc, output int e_pc, output int e_er,
                        output int e_fa, output int e_cyc);
      int n;
      n = la_p[k] - fa_p[k] + 1;
      e_tc = 0; e_pc = 0; e_er = 0; e_fa = 0;
      for (int a = fa_p[k]; a <= la_p[k]; a++) begin
         e_tc++;
         if (addr_ok(a, s)) e_pc++;
         else if (e_er == 0) begin
            e_er = 1;
            e_fa = a;
`ifdef BIST_STOP_ON_FAIL_EN
            break;
`endif
         end
      end
      e_cyc = n + e_tc * (rl_p[k] + 1);
   endtask

   task automatic clear_faults();
      for (int a = 0; a < 32; a++) begin
         or_mask[a] = '0;
         x2_mask[a] = '0;
      end
   endtask

   task automatic run_check(input string tag, input int k, input logic [31:0] s,
                            input bit hold, input int e_tc, input int e_pc,
                            input int e_er, input int e_fa, input int e_cyc,
                            output int base);
      int cyc, bad0, n, wbad;
      n = la_p[k] - fa_p[k] + 1;
      @(negedge clk);
      cur = k;
      base = wr_log.size();
      bad0 = excl_bad;
      seed[k] = s;
      start[k] = 1'b1;
      @(posedge clk); #1;
      chk({tag, ".busy_rise"}, {31'd0, busy[k]}, 1);
      chk({tag, ".done_clr"}, {31'd0, done[k]}, 0);
      @(negedge clk);
      if (!hold) start[k] = 1'b0;
      cyc = 0;
      while (!done[k] && cyc < 400) begin
         @(posedge clk); #1;
         cyc++;
      end
      chk({tag, ".cycles"}, cyc, e_cyc);
      chk({tag, ".test_count"}, {26'd0, tc[k]}, e_tc);
      chk({tag, ".pass_count"}, {26'd0, pc[k]}, e_pc);
      chk({tag, ".error"}, {31'd0, err[k]}, e_er);
      chk({tag, ".fail_addr"}, {27'd0, fa[k]}, e_fa);
      chk({tag, ".done_idle_out"},
          {busy[k], rd[k], wr[k], addr_w[k], addr_r1[k], addr_r2[k]}, 0);
      chk({tag, ".done_data_w"}, data_w[k], 0);
      @(negedge clk);
      start[k] = 1'b0;
      wbad = 0;
      for (int i = 0; i < n; i++) begin
         if (base + i >= wr_log.size()) wbad++;
         else if (wr_log[base + i] !== {5'(fa_p[k] + i), pat(fa_p[k] + i, s)})
            wbad++;
      end
      chk({tag, ".write_seq"}, wbad, 0);
      chk({tag, ".write_count"}, wr_log.size() - base, n);
      chk({tag, ".rw_exclusive"}, excl_bad - bad0, 0);
      repeat (2) @(posedge clk);
      #1 chk({tag, ".done_held"}, {31'd0, done[k]}, 1);
   endtask

   typedef struct {
      int          inst;
      logic [31:0] seed;
      int          stuck_a;
      int          x2_a;
      logic [31:0] x2_m;
      int          tc;
      int          pc;
      int          er;
      int          fa;
      int          cyc;
   } vec_t;

   vec_t vt[5];

   initial begin
      int base, e_tc, e_pc, e_er, e_fa, e_cyc, k, n, nf, a, to;
      logic [31:0] s;

      vt[0] = '{0, 32'h0000_0000, -1, -1, 32'h0, 31, 31, 0, 0, 93};
      vt[1] = '{0, 32'hFFFF_0000, -1, -1, 32'h0, 31, 31, 0, 0, 93};
`ifdef BIST_STOP_ON_FAIL_EN
      vt[2] = '{0, 32'h0000_0000, 7, -1, 32'h0, 7, 6, 1, 7, 45};
      vt[4] = '{2, 32'h1234_5678, 7, 4, 32'h100, 3, 2, 1, 4, 17};
`else
      vt[2] = '{0, 32'h0000_0000, 7, -1, 32'h0, 31, 30, 1, 7, 93};
      vt[4] = '{2, 32'h1234_5678, 7, 4, 32'h100, 8, 6, 1, 4, 32};
`endif
      vt[3] = '{1, 32'h0000_0000, -1, -1, 32'h0, 1, 1, 0, 0, 2};

      for (int i = 0; i < NI; i++) begin
         start[i] = 1'b0;
         seed[i] = '0;
      end
      clear_faults();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      for (int i = 0; i < NI; i++) begin
         chk($sformatf("reset%0d.flags", i),
             {busy[i], done[i], err[i], rd[i], wr[i]}, 0);
         chk($sformatf("reset%0d.addr_cnt", i),
             {addr_w[i], addr_r1[i], fa[i], tc[i], pc[i]}, 0);
      end
      @(negedge clk);
      rst = 1'b0;
      repeat (2) @(posedge clk);

      for (int v = 0; v < 5; v++) begin
         clear_faults();
         if (vt[v].stuck_a >= 0) or_mask[vt[v].stuck_a] = 32'h1;
         if (vt[v].x2_a >= 0) x2_mask[vt[v].x2_a] = vt[v].x2_m;
         run_check($sformatf("vec%0d", v), vt[v].inst, vt[v].seed, 1'b0,
                   vt[v].tc, vt[v].pc, vt[v].er, vt[v].fa, vt[v].cyc, base);
         if (v == 1) chk("vec1.addr5_data", wr_log[base + 4][31:0], 32'hFFFF_000A);
      end

      for (int it = 0; it < 8; it++) begin
         clear_faults();
         k = int'($urandom_range(0, 2));
         s = $urandom;
         n = la_p[k] - fa_p[k] + 1;
         nf = int'($urandom_range(0, 2));
         for (int f = 0; f < nf; f++) begin
            a = fa_p[k] + int'($urandom_range(0, n - 1));
            if ($urandom_range(0, 1) == 1)
               or_mask[a] = or_mask[a] | (32'h1 << $urandom_range(0, 31));
            else
               x2_mask[a] = 32'h1 << $urandom_range(0, 31);
         end
         model(k, s, e_tc, e_pc, e_er, e_fa, e_cyc);
         run_check($sformatf("rand%0d", it), k, s, 1'b0,
                   e_tc, e_pc, e_er, e_fa, e_cyc, base);
      end

      // abort in the middle of the read phase
      clear_faults();
      @(negedge clk);
      cur = 0;
      seed[0] = 32'h0;
      start[0] = 1'b1;
      to = 0;
      do begin
         @(posedge clk); #1;
         to++;
      end while (!(rd[0] && addr_r1[0] == 5'd12) && to < 200);
      chk("abort.reach_rd12", {31'd0, rd[0] && addr_r1[0] == 5'd12}, 1);
      #2 rst = 1'b1;
      #1;
      chk("abort.flags", {busy[0], done[0], err[0], rd[0], wr[0]}, 0);
      chk("abort.addrs", {addr_w[0], addr_r1[0], addr_r2[0], fa[0]}, 0);
      chk("abort.data_w", data_w[0], 0);
      chk("abort.counts", {tc[0], pc[0]}, 0);
      @(negedge clk);
      start[0] = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      repeat (3) @(posedge clk);
      #1 chk("abort.stays_idle", {busy[0], done[0], rd[0], wr[0]}, 0);
      run_check("restart_hold", 0, 32'h0, 1'b1, 31, 31, 0, 0, 93, base);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_assert, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
